// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles big-endian words from a UART byte stream and writes them from @0.
// Optional IMEM_LOADER_CLEAR_EN zero-fills the whole memory before receiving.
module imem_loader #(
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [31:0]           pc_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_stall,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [1:0]            r_idx;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  w_ptr_last;
  logic                  w_unused_pc_bits;

  assign w_ptr_last       = (r_ptr == {ADDR_WIDTH{1'b1}});
  assign w_unused_pc_bits = ^{pc_addr[31:ADDR_WIDTH+2], pc_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end
`ifdef IMEM_LOADER_CLEAR_EN
        S_CLEAR: r_ptr <= w_ptr_last ? '0 : r_ptr + 1'b1;
`endif
        S_RECV: begin
          if (rx_valid) begin
            r_word <= {r_word[23:0], rx_data};
            r_idx  <= r_idx + 1'b1;
          end
        end
        S_WRITE: begin
          r_count <= r_count + 1'b1;
          // Pointer saturates at the top word rather than wrapping to 0.
          if (!w_ptr_last)
            r_ptr <= r_ptr + 1'b1;
          if ((r_word != HALT_WORD) && w_ptr_last)
            r_overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    rx_ready     = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    mem_addr     = r_ptr;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_addr = pc_addr[ADDR_WIDTH+1:2];
        if (start) begin
`ifdef IMEM_LOADER_CLEAR_EN
          w_state_next = S_CLEAR;
`else
          w_state_next = S_RECV;
`endif
        end
      end
`ifdef IMEM_LOADER_CLEAR_EN
      S_CLEAR: begin
        mem_we = 1'b1;
        if (w_ptr_last)
          w_state_next = S_RECV;
      end
`endif
      S_RECV: begin
        rx_ready = 1'b1;
        if (rx_valid && (r_idx == 2'd3))
          w_state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = r_word;
        if ((r_word == HALT_WORD) || w_ptr_last)
          w_state_next = S_DONE;
        else
          w_state_next = S_RECV;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign busy       = (r_state != S_IDLE);
  assign cpu_stall  = busy;
  assign word_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader and port controller for the 512-word instruction memory. It receives a byte stream from the debug UART receiver and assembles big-endian 32-bit words. It writes those words sequentially from address 0, holding the CPU stalled for the whole load. While idle it gives the memory address port to the fetch stage's PC.

## Interface

Parameters:
- `ADDR_WIDTH`, 9: word-address width; memory depth is 2^ADDR_WIDTH words (512).
- `HALT_WORD`, 32'hFFFFFFFF: end-of-program marker; it is itself written to memory.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `pc_addr`  in  32  byte address from fetch.
- `mem_addr`  out  ADDR_WIDTH  word address to instruction memory.
- `mem_wdata`  out  32  write data.
- `mem_we`  out  1  write enable, one cycle per word.
- `cpu_stall`  out  1  freezes PC and pipeline.
- `busy`  out  1  loader not in IDLE.
- `done`  out  1  one-cycle pulse at end of load.
- `word_count`  out  ADDR_WIDTH+1  words written in the last or current load.
- `overflow`  out  1  memory filled without seeing `HALT_WORD`; sticky.

## Operation

States:
- IDLE
- CLEAR (only with macro)
- RECV
- WRITE
- DONE

Transitions:
- IDLE → (CLEAR or RECV) on `start`. On entry: clear the write pointer, byte index, `word_count` and `overflow`.
- RECV: `rx_ready`=1. Each `rx_valid && rx_ready` shifts the byte in, first byte to [31:24], and increments the 2-bit byte index. The 4th byte goes to WRITE.
- WRITE: `mem_we`=1, `mem_addr`=pointer, `mem_wdata`=assembled word, `rx_ready`=0. Next edge: pointer++ and `word_count`++.
  - If the word == `HALT_WORD`, go to DONE.
  - Else if the pointer was 2^ADDR_WIDTH−1, set `overflow` and go to DONE.
  - Else go back to RECV.
- DONE: `done`=1 for one cycle, then IDLE.

Outputs and muxing:
- `mem_addr` = `pc_addr[ADDR_WIDTH+1:2]` when IDLE, loader pointer otherwise. The pointer never wraps.
- `busy` = `cpu_stall` = (state != IDLE).
- `mem_we` is asserted only in WRITE and CLEAR.

Reset mid-operation returns to IDLE immediately:
- A partial word is discarded.
- Memory keeps whatever was already written.
- `word_count` and `overflow` are zeroed.

## Timing

- Reset values: `rx_ready`, `mem_we`, `cpu_stall`, `busy`, `done`, `overflow` = 0; `word_count` = 0; `mem_wdata` = 0; `mem_addr` follows `pc_addr`.
- `cpu_stall` rises the cycle after `start` is sampled. It falls the cycle after DONE, so the CPU resumes fetch one cycle after the `done` pulse.
- Per word: 4 accepted-byte cycles (rx gaps allowed, any length) + 1 WRITE cycle. Minimum 5 cycles/word.
- `rx_valid` during WRITE/DONE/IDLE is not consumed; the byte source must hold it.
- `start` coincident with reset: reset wins.

## Configuration

- `IMEM_LOADER_CLEAR_EN` defined: after `start`, CLEAR writes 0 to addresses 0..2^ADDR_WIDTH−1, one per cycle with `mem_we`=1 (512 cycles), then enters RECV with the pointer back at 0. `word_count` is not incremented in CLEAR.
- Not defined: `start` goes directly to RECV; unloaded words keep prior contents.

## Test plan

- Reset then idle, `pc_addr`=0x18 → `mem_addr`=6, `cpu_stall`=0, `mem_we`=0.
- `start`, bytes 02 53 88 20 FF FF FF FF back-to-back:
  - writes 0x02538820 @0, then 0xFFFFFFFF @1;
  - `done` pulse; `word_count`=2, `overflow`=0;
  - `cpu_stall` high from cycle after `start` until cycle after `done`.
- Same stream with random 0–3 cycle `rx_valid` gaps and a byte held through WRITE → identical writes, no byte lost or duplicated.
- 512 words of 0x00000000, no halt → last write @511, `overflow`=1, `word_count`=512, `done`. A following `start` clears `overflow`.
- `rst_n` low after 2 bytes of word 3 → IDLE at once, `cpu_stall`=0, no write to @3. A new load restarts at @0.
- With `IMEM_LOADER_CLEAR_EN`:
  - `start` → 512 consecutive zero writes @0..511, then RECV;
  - `start` pulsed during CLEAR is ignored.
